// File: rtl/temp_pkg.sv
// Shared types and defaults for the multi-zone thermostat scheduler.
package temp_pkg;

    // Per-zone actuator mode; HEAT and COOL are mutually exclusive by construction
    typedef enum logic [1:0] {
        OFF  = 2'd0,
        HEAT = 2'd1,
        COOL = 2'd2
    } mode_t;

    // Scheduler FSM: each zone visit is one LOAD cycle followed by one EVAL cycle
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EVAL = 2'd2
    } state_t;

    localparam int DEF_NZ   = 4;
    localparam int DEF_W    = 7;
    localparam int DEF_HOLD = 2;

    // Width needed to hold values 0..n-1, never narrower than one bit
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/temp_hyst_eval.sv
// Combinational hysteresis decision for one zone: current mode plus sampled
// temperatures in, next mode out. Sums are formed one bit wider than the
// operands so troom+dt and tref+dt can never wrap.
module temp_hyst_eval
    import temp_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  mode_t          i_mode,
    input  logic [W-1:0]   i_troom,
    input  logic [W-1:0]   i_tref,
    input  logic [W-1:0]   i_dt,
    output mode_t          o_mode
);

    logic [W:0] w_room;
    logic [W:0] w_ref;
    logic [W:0] w_room_plus_dt;
    logic [W:0] w_ref_plus_dt;

    assign w_room         = {1'b0, i_troom};
    assign w_ref          = {1'b0, i_tref};
    assign w_room_plus_dt = {1'b0, i_troom} + {1'b0, i_dt};
    assign w_ref_plus_dt  = {1'b0, i_tref} + {1'b0, i_dt};

    // Next-mode decision; an active mode can only fall back to OFF, never swap directly
    always_comb begin
        o_mode = i_mode;
        case (i_mode)
            OFF: begin
                if (w_room_plus_dt < w_ref) begin
                    o_mode = HEAT;
                end else if (w_room > w_ref_plus_dt) begin
                    o_mode = COOL;
                end
            end
            HEAT: begin
                if (w_room >= w_ref) begin
                    o_mode = OFF;
                end
            end
            COOL: begin
                if (w_room <= w_ref) begin
                    o_mode = OFF;
                end
            end
            default: o_mode = OFF;
        endcase
    end

endmodule

// File: rtl/temp_zone_sched.sv
// Round-robin scheduler sharing one hysteresis evaluator across NZ zones.
// Each zone visit is LOAD (capture that zone's inputs) then EVAL (update its
// mode, honouring the anti-short-cycle hold). Dropping start returns to IDLE
// and turns every zone off.
//
// start is a plain level enable, not a handshake: it is sampled in IDLE to
// begin scanning and in EVAL to decide between the next zone and IDLE; its
// value during LOAD is ignored.
module temp_zone_sched
    import temp_pkg::*;
#(
    parameter  int NZ   = DEF_NZ,
    parameter  int W    = DEF_W,
    parameter  int HOLD = DEF_HOLD,
    localparam int ZW   = clog2_min1(NZ),
    localparam int HW   = clog2_min1(HOLD + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [NZ*W-1:0]   troom,
    input  logic [NZ*W-1:0]   tref,
    input  logic [W-1:0]      dt,
    output logic [NZ-1:0]     h,
    output logic [NZ-1:0]     c,
    output logic              busy,
    output logic [ZW-1:0]     zone,
    output state_t            o_dbg_state
);

    state_t          r_state;
    state_t          w_next_state;
    logic            w_load_en;
    logic            w_eval_en;

    logic [ZW-1:0]   r_zone;
    logic [W-1:0]    r_troom;
    logic [W-1:0]    r_tref;
    logic [W-1:0]    r_dt;

    mode_t           r_mode [NZ];
    logic [HW-1:0]   r_hold [NZ];
    logic [NZ-1:0]   r_h;
    logic [NZ-1:0]   r_c;

    mode_t           w_cur_mode;
    mode_t           w_eval_mode;
    logic [HW-1:0]   w_cur_hold;
    logic            w_zone_last;

    assign w_cur_mode  = r_mode[r_zone];
    assign w_cur_hold  = r_hold[r_zone];
    assign w_zone_last = (r_zone == ZW'(NZ - 1));

    temp_hyst_eval #(
        .W (W)
    ) u_eval (
        .i_mode  (w_cur_mode),
        .i_troom (r_troom),
        .i_tref  (r_tref),
        .i_dt    (r_dt),
        .o_mode  (w_eval_mode)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start) w_next_state = LOAD;
            LOAD:    w_next_state = EVAL;
            EVAL:    w_next_state = start ? LOAD : IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // FSM outputs: phase strobes for the datapath and the busy flag
    always_comb begin
        w_load_en = (r_state == LOAD);
        w_eval_en = (r_state == EVAL);
        busy      = (r_state != IDLE);
    end

    // Capture the current zone's temperatures and the shared band during LOAD
    always_ff @(posedge clk) begin
        if (reset) begin
            r_troom <= '0;
            r_tref  <= '0;
            r_dt    <= '0;
        end else if (w_load_en) begin
            r_troom <= troom[r_zone*W +: W];
            r_tref  <= tref[r_zone*W +: W];
            r_dt    <= dt;
        end
    end

    // EVAL: update one zone's mode/hold and advance, or clear everything on IDLE entry
    always_ff @(posedge clk) begin
        if (reset) begin
            r_zone <= '0;
            r_h    <= '0;
            r_c    <= '0;
            for (int i = 0; i < NZ; i++) begin
                r_mode[i] <= OFF;
                r_hold[i] <= '0;
            end
        end else if (w_eval_en) begin
            if (!start) begin
                // The in-flight decision is discarded; all zones go off together
                r_zone <= '0;
                r_h    <= '0;
                r_c    <= '0;
                for (int i = 0; i < NZ; i++) begin
                    r_mode[i] <= OFF;
                    r_hold[i] <= '0;
                end
            end else begin
                r_zone <= w_zone_last ? '0 : r_zone + 1'b1;
                if (w_cur_hold != '0) begin
                    r_hold[r_zone] <= w_cur_hold - 1'b1;
                end else if (w_eval_mode != w_cur_mode) begin
                    r_mode[r_zone] <= w_eval_mode;
                    r_hold[r_zone] <= HW'(HOLD);
                    r_h[r_zone]    <= (w_eval_mode == HEAT);
                    r_c[r_zone]    <= (w_eval_mode == COOL);
                end
            end
        end
    end

    assign h           = r_h;
    assign c           = r_c;
    assign zone        = r_zone;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_temp_zone_sched.sv
// Bench for temp_zone_sched with NZ=4, W=7, HOLD=2.
module tb_temp_zone_sched;
    import temp_pkg::*;

    localparam int NZ   = 4;
    localparam int W    = 7;
    localparam int HOLD = 2;
    localparam int ZW   = 2;
    localparam int EW   = 1 + ZW + 2 * NZ;
    localparam int TMO  = 4 * NZ + 8;

    // ---------------- clock / reset ----------------
    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [NZ*W-1:0]   troom;
    logic [NZ*W-1:0]   tref;
    logic [W-1:0]      dt;
    logic [NZ-1:0]     h;
    logic [NZ-1:0]     c;
    logic              busy;
    logic [ZW-1:0]     zone;
    state_t            dbg_state;

    always #5 clk = ~clk;

    temp_zone_sched #(
        .NZ   (NZ),
        .W    (W),
        .HOLD (HOLD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .troom       (troom),
        .tref        (tref),
        .dt          (dt),
        .h           (h),
        .c           (c),
        .busy        (busy),
        .zone        (zone),
        .o_dbg_state (dbg_state)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [EW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // ---------------- reference model ----------------
    // modes: 0 off, 1 heat, 2 cool; states: 0 idle, 1 load, 2 eval
    int m_state = 0;
    int m_zone  = 0;
    int m_mode [NZ];
    int m_hold [NZ];
    int m_tr, m_rf, m_dt;
    bit m_evt = 1'b0;
    int m_evt_zone = 0;

    function automatic int model_next(input int mode, input int tr, input int rf, input int d);
        if (mode == 0) begin
            if (tr + d < rf) return 1;
            if (tr > rf + d) return 2;
            return 0;
        end
        if (mode == 1) return (tr >= rf) ? 0 : 1;
        return (tr <= rf) ? 0 : 2;
    endfunction

    always @(posedge clk) begin : model
        logic [NZ-1:0] eh;
        logic [NZ-1:0] ec;
        int nm;
        m_evt = 1'b0;
        if (reset) begin
            m_state = 0;
            m_zone  = 0;
            for (int i = 0; i < NZ; i++) begin m_mode[i] = 0; m_hold[i] = 0; end
        end else begin
            case (m_state)
                0: if (start) m_state = 1;
                1: begin
                    m_tr = int'(troom[m_zone*W +: W]);
                    m_rf = int'(tref[m_zone*W +: W]);
                    m_dt = int'(dt);
                    m_state = 2;
                end
                default: begin
                    nm = model_next(m_mode[m_zone], m_tr, m_rf, m_dt);
                    if (m_hold[m_zone] > 0) m_hold[m_zone]--;
                    else if (nm != m_mode[m_zone]) begin
                        m_mode[m_zone] = nm;
                        m_hold[m_zone] = HOLD;
                    end
                    m_evt = 1'b1;
                    m_evt_zone = m_zone;
                    if (start) begin
                        m_zone  = (m_zone + 1) % NZ;
                        m_state = 1;
                    end else begin
                        for (int i = 0; i < NZ; i++) begin m_mode[i] = 0; m_hold[i] = 0; end
                        m_zone  = 0;
                        m_state = 0;
                    end
                end
            endcase
        end
        for (int i = 0; i < NZ; i++) begin
            eh[i] = (m_mode[i] == 1);
            ec[i] = (m_mode[i] == 2);
        end
        exp_q.push_back({(m_state != 0), ZW'(m_zone), eh, ec});
    end

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("cycle{busy,zone,h,c}", 32'({busy, zone, h, c}), 32'(e));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_zone(input int z, input int tr, input int rf);
        troom[z*W +: W] = W'(tr);
        tref[z*W +: W]  = W'(rf);
    endtask

    task automatic wait_visit(input int z);
        bit found = 1'b0;
        for (int i = 0; i < TMO && !found; i++) begin
            @(negedge clk);
            if (m_evt && m_evt_zone == z) found = 1'b1;
        end
        if (!found) begin
            n_checks++;
            n_errors++;
            $error("FAIL visit_timeout: zone %0d not evaluated within %0d cycles", z, TMO);
        end
    endtask

    task automatic stop_scan();
        start = 1'b0;
        for (int i = 0; i < TMO && m_state != 0; i++) @(negedge clk);
        check("stop_busy", 32'(busy), 32'd0);
        check("stop_h", 32'(h), 32'd0);
        check("stop_c", 32'(c), 32'd0);
    endtask

    task automatic wait_model(input int st, input int z);
        bit found = 1'b0;
        for (int i = 0; i < TMO && !found; i++) begin
            @(negedge clk);
            if (m_state == st && m_zone == z) found = 1'b1;
        end
        if (!found) begin
            n_checks++;
            n_errors++;
            $error("FAIL state_timeout: state %0d zone %0d not reached", st, z);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset = 1'b1;
        start = 1'b0;
        dt    = 7'd1;
        for (int z = 0; z < NZ; z++) set_zone(z, 60, 60);
        @(negedge clk);
        @(negedge clk);
        check("rst_h", 32'(h), 32'd0);
        check("rst_c", 32'(c), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_zone", 32'(zone), 32'd0);

        // all zones at setpoint for three full rounds
        reset = 1'b0;
        start = 1'b1;
        repeat (3 * 2 * NZ + 1) @(negedge clk);
        check("flat_h", 32'(h), 32'd0);
        check("flat_c", 32'(c), 32'd0);
        check("flat_busy", 32'(busy), 32'd1);
        stop_scan();

        // heat on: h[0] two cycles after start is sampled
        set_zone(0, 50, 60);
        start = 1'b1;
        @(negedge clk);
        check("start_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("heat_early_h", 32'(h), 32'd0);
        @(negedge clk);
        check("heat_on_h", 32'(h), 32'b0001);
        check("heat_on_c", 32'(c), 32'd0);

        // hold, then OFF, then hold again, then COOL
        set_zone(0, 80, 60);
        wait_visit(0); check("hold1_h", 32'(h), 32'b0001);
        wait_visit(0); check("hold2_h", 32'(h), 32'b0001);
        wait_visit(0); check("swap_off_h", 32'(h), 32'd0);
        check("swap_off_c", 32'(c), 32'd0);
        wait_visit(0); check("off_hold1_c", 32'(c), 32'd0);
        wait_visit(0); check("off_hold2_c", 32'(c), 32'd0);
        wait_visit(0); check("cool_on_c", 32'(c), 32'b0001);
        check("cool_on_h", 32'(h), 32'd0);
        stop_scan();

        // band edges with tref=60, dt=1: 59 off, 58 heat, 61 off, 62 cool
        set_zone(0, 59, 60);
        set_zone(1, 58, 60);
        set_zone(2, 61, 60);
        set_zone(3, 62, 60);
        start = 1'b1;
        wait_visit(3);
        check("band_h", 32'(h), 32'b0010);
        check("band_c", 32'(c), 32'b1000);
        stop_scan();

        // low-end guard
        dt = 7'd5;
        set_zone(0, 0, 0);
        set_zone(1, 60, 60);
        set_zone(2, 60, 60);
        set_zone(3, 60, 60);
        start = 1'b1;
        wait_visit(3);
        check("guard_lo_h", 32'(h), 32'd0);
        check("guard_lo_c", 32'(c), 32'd0);
        stop_scan();

        // high-end guard: sums reach 254 and must not wrap
        dt = 7'd127;
        set_zone(0, 127, 127);
        set_zone(1, 127, 0);
        set_zone(2, 0, 127);
        set_zone(3, 60, 60);
        start = 1'b1;
        wait_visit(3);
        check("guard_hi_h", 32'(h), 32'd0);
        check("guard_hi_c", 32'(c), 32'd0);
        stop_scan();

        // start dropped during zone2 LOAD
        dt = 7'd1;
        set_zone(0, 50, 60);
        set_zone(1, 60, 60);
        set_zone(2, 60, 60);
        set_zone(3, 70, 60);
        start = 1'b1;
        wait_visit(3);
        check("pre_drop_h", 32'(h), 32'b0001);
        check("pre_drop_c", 32'(c), 32'b1000);
        wait_model(1, 2);
        check("drop_load_zone", 32'(zone), 32'd2);
        start = 1'b0;
        @(negedge clk);
        check("drop_eval_busy", 32'(busy), 32'd1);
        check("drop_eval_h", 32'(h), 32'b0001);
        @(negedge clk);
        check("drop_idle_busy", 32'(busy), 32'd0);
        check("drop_idle_h", 32'(h), 32'd0);
        check("drop_idle_c", 32'(c), 32'd0);
        check("drop_idle_zone", 32'(zone), 32'd0);

        // reset during EVAL
        start = 1'b1;
        wait_visit(3);
        check("pre_rst_h", 32'(h), 32'b0001);
        check("pre_rst_c", 32'(c), 32'b1000);
        wait_model(2, 1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_h", 32'(h), 32'd0);
        check("mid_rst_c", 32'(c), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_zone", 32'(zone), 32'd0);
        reset = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
